// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg
// Description : Enable-gated delay line; one image row of pixel storage.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg #(
    parameter int NUM_REGS = 320,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              shift,
    input  logic [DATA_W-1:0] sr_in,
    output logic [DATA_W-1:0] sr_out
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Contents are intentionally not reset; downstream gating hides stale data.
    always_ff @(posedge clk) begin
        if (shift) begin
            r_regs[0] <= sr_in;
            for (int k = 1; k < NUM_REGS; k++) begin
                r_regs[k] <= r_regs[k-1];
            end
        end
    end

    assign sr_out = r_regs[NUM_REGS-1];

endmodule

// ============================================================================
// Module      : window_3x3_gen
// Description : Sliding 3x3 pixel window over a raster stream using two
//               row line buffers, with centre row/column tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module window_3x3_gen #(
    parameter  int IMG_WIDTH  = 320,
    parameter  int IMG_HEIGHT = 240,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [71:0]   win,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          frame_done
);

    localparam logic [CW-1:0] c_col_last = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_HEIGHT - 1);

    logic          w_accept;
    logic          w_shift;
    logic [7:0]    w_lb0_out;
    logic [7:0]    w_lb1_out;
    logic [CW-1:0] w_col_pos;
    logic [RW-1:0] w_row_pos;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_w [3][3];
    logic          r_win_valid;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic          r_frame_done;

    assign w_accept = pix_valid;
    // A pixel arriving together with reset is dropped, so the buffers hold too.
    assign w_shift  = pix_valid & ~reset;

    shift_reg #(.NUM_REGS(IMG_WIDTH), .DATA_W(8)) u_lb0 (
        .clk    (clk),
        .shift  (w_shift),
        .sr_in  (pix_in),
        .sr_out (w_lb0_out)
    );

    shift_reg #(.NUM_REGS(IMG_WIDTH), .DATA_W(8)) u_lb1 (
        .clk    (clk),
        .shift  (w_shift),
        .sr_in  (w_lb0_out),
        .sr_out (w_lb1_out)
    );

    // sof relabels the accepted pixel as (0,0) before any decisions are made.
    always_comb begin
        w_col_pos = sof ? '0 : r_col;
        w_row_pos = sof ? '0 : r_row;
        w_col_nxt = w_col_pos + CW'(1);
        w_row_nxt = w_row_pos;
        if (w_col_pos == c_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row_pos == c_row_last) ? '0 : w_row_pos + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_w[i][j] <= '0;
                end
            end
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_col       <= w_col_nxt;
                r_row       <= w_row_nxt;
                r_win_valid <= (w_row_pos >= RW'(2)) && (w_col_pos >= CW'(2));
                r_win_row   <= w_row_pos - RW'(1);
                r_win_col   <= w_col_pos - CW'(1);
                // Uses the counter position, so a frame wrap still reports even under sof.
                r_frame_done <= (r_row == c_row_last) && (r_col == c_col_last);
                for (int i = 0; i < 3; i++) begin
                    r_w[i][0] <= r_w[i][1];
                    r_w[i][1] <= r_w[i][2];
                end
                r_w[0][2] <= w_lb1_out;
                r_w[1][2] <= w_lb0_out;
                r_w[2][2] <= pix_in;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            for (genvar gj = 0; gj < 3; gj++) begin : g_win_col
                assign win[8*(3*gi+gj) +: 8] = r_w[gi][gj];
            end
        end
    endgenerate

    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
